// File: rtl/kernel_run_ctrl.sv
// Run sequencer for an ap_ctrl_hs HLS kernel: repeated starts, dataset advance handshake, done watchdog.
// Optional latency statistics (lat_last/lat_max) are built when RUN_CTRL_LAT_STATS_EN is defined.
module kernel_run_ctrl #(
    parameter int CNT_W          = 16,
    parameter int DATASET_NUM    = 8,
    parameter int RAM_UPDATE_INV = 1,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int LAT_W          = 32,
    localparam int DS_W          = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             run_req,
    input  logic [CNT_W-1:0] run_count,
    output logic             k_ap_start,
    input  logic             k_ap_ready,
    input  logic             k_ap_done,
    output logic             ds_update,
    input  logic             ds_ready,
    output logic [DS_W-1:0]  ds_index,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err_timeout,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_max
);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int UPD_W = $clog2(RAM_UPDATE_INV + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WAIT_DONE, ST_UPDATE, ST_GAP, ST_FINISH
    } state_t;

    state_t             state_reg, state_next;
    logic               run_req_q;
    logic [CNT_W-1:0]   run_count_reg, run_count_next;
    logic [CNT_W-1:0]   iter_reg, iter_next, iter_inc;
    logic [UPD_W-1:0]   upd_reg, upd_next, upd_inc;
    logic [TO_W-1:0]    lat_reg, lat_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [DS_W-1:0]    ds_index_reg, ds_index_next;
    logic               start_reg, start_next;
    logic               ds_update_reg, ds_update_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               req_edge, stop_cont, complete, go_gap, gap_exit;

    assign req_edge  = run_req & ~run_req_q;
    assign stop_cont = (run_count_reg == '0) && !run_req;

    always_comb begin
        state_next     = state_reg;
        run_count_next = run_count_reg;
        iter_next      = iter_reg;
        upd_next       = upd_reg;
        lat_next       = lat_reg;
        gap_next       = gap_reg;
        ds_index_next  = ds_index_reg;
        start_next     = 1'b0;
        ds_update_next = 1'b0;
        done_next      = done_reg;
        err_next       = err_reg;
        complete       = 1'b0;
        go_gap         = 1'b0;
        gap_exit       = 1'b0;
        iter_inc       = (&iter_reg) ? iter_reg : iter_reg + 1'b1;
        upd_inc        = upd_reg + 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (req_edge) begin
                    run_count_next = run_count;
                    iter_next      = '0;
                    upd_next       = '0;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
                    start_next     = 1'b1;
                    state_next     = ST_START;
                end
            end
            ST_START: begin
                start_next = 1'b1;
                if (k_ap_ready) begin
                    start_next = 1'b0;
                    lat_next   = TO_W'(1);
                    if (k_ap_done) complete = 1'b1;
                    else           state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                lat_next = lat_reg + 1'b1;
                if (k_ap_done) begin
                    complete = 1'b1;
                end else if (lat_reg == TO_W'(TIMEOUT_CYCLES)) begin
                    err_next   = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_UPDATE: begin
                // ds_ready is ignored during the pulse cycle so a stale "idle" cannot skip the update
                if (!ds_update_reg && ds_ready) begin
                    if (stop_cont) state_next = ST_FINISH;
                    else           go_gap = 1'b1;
                end
            end
            ST_GAP: begin
                gap_next = gap_reg + 1'b1;
                if (gap_reg == GAP_W'(GAP_CYCLES - 1)) gap_exit = 1'b1;
            end
            ST_FINISH: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (complete) begin
            iter_next = iter_inc;
            if ((run_count_reg != '0 && iter_inc == run_count_reg) || stop_cont) begin
                state_next = ST_FINISH;
            end else if (upd_inc == UPD_W'(RAM_UPDATE_INV)) begin
                upd_next       = '0;
                ds_update_next = 1'b1;
                ds_index_next  = (ds_index_reg == DS_W'(DATASET_NUM - 1)) ? '0 : ds_index_reg + 1'b1;
                state_next     = ST_UPDATE;
            end else begin
                upd_next = upd_inc;
                go_gap   = 1'b1;
            end
        end

        if (go_gap) begin
            if (GAP_CYCLES == 0) begin
                gap_exit = 1'b1;
            end else begin
                gap_next   = '0;
                state_next = ST_GAP;
            end
        end

        if (gap_exit) begin
            if (stop_cont) begin
                state_next = ST_FINISH;
            end else begin
                start_next = 1'b1;
                state_next = ST_START;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_reg     <= ST_IDLE;
            run_req_q     <= 1'b1;  // a level already high at reset release is not an edge
            run_count_reg <= '0;
            iter_reg      <= '0;
            upd_reg       <= '0;
            lat_reg       <= '0;
            gap_reg       <= '0;
            ds_index_reg  <= '0;
            start_reg     <= 1'b0;
            ds_update_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_req_q     <= run_req;
            run_count_reg <= run_count_next;
            iter_reg      <= iter_next;
            upd_reg       <= upd_next;
            lat_reg       <= lat_next;
            gap_reg       <= gap_next;
            ds_index_reg  <= ds_index_next;
            start_reg     <= start_next;
            ds_update_reg <= ds_update_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign k_ap_start  = start_reg;
    assign ds_update   = ds_update_reg;
    assign ds_index    = ds_index_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign iter_cnt    = iter_reg;
    assign err_timeout = err_reg;

`ifdef RUN_CTRL_LAT_STATS_EN
    logic [LAT_W-1:0] lat_last_reg, lat_max_reg, lat_now;

    // A same-cycle ready+done completion counts as latency 1
    assign lat_now = (state_reg == ST_START) ? LAT_W'(1) : LAT_W'(lat_reg);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            lat_last_reg <= '0;
            lat_max_reg  <= '0;
        end else if (state_reg == ST_IDLE && req_edge) begin
            lat_max_reg <= '0;
        end else if (complete) begin
            lat_last_reg <= lat_now;
            if (lat_now > lat_max_reg) lat_max_reg <= lat_now;
        end
    end

    assign lat_last = lat_last_reg;
    assign lat_max  = lat_max_reg;
`else
    assign lat_last = '0;
    assign lat_max  = '0;
`endif
endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Directed bench for kernel_run_ctrl: table of request vectors plus hand sequences for
// continuous mode, slow dataset loaders, watchdog timeout and mid-run reset.
module tb_kernel_run_ctrl;
    localparam int CNT_W = 16;
    localparam int LAT_W = 32;

    logic             clk = 1'b0;
    logic             ap_rst;
    logic             run_req;
    logic [CNT_W-1:0] run_count;
    logic             k_ap_start;
    logic             k_ap_ready;
    logic             k_ap_done;
    logic             ds_update;
    logic             ds_ready;
    logic [2:0]       ds_index;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_cnt;
    logic             err_timeout;
    logic [LAT_W-1:0] lat_last;
    logic [LAT_W-1:0] lat_max;

    kernel_run_ctrl #(
        .CNT_W(CNT_W), .DATASET_NUM(8), .RAM_UPDATE_INV(2),
        .GAP_CYCLES(4), .TIMEOUT_CYCLES(100), .LAT_W(LAT_W)
    ) dut (
        .ap_clk(clk), .ap_rst(ap_rst), .run_req(run_req), .run_count(run_count),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
        .ds_update(ds_update), .ds_ready(ds_ready), .ds_index(ds_index),
        .busy(busy), .done(done), .iter_cnt(iter_cnt), .err_timeout(err_timeout),
        .lat_last(lat_last), .lat_max(lat_max)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Kernel / loader model state (written only by the responder process)
    int  starts = 0, pulses = 0, k_cnt = 0, err_at = -1;
    int  ds_low_left = 0, since = 0, gap_meas = -1;
    int  upd_wide = 0, start_low = 0;
    bit  k_busy = 0, measuring = 0;
    logic prev_err = 1'b0, prev_upd = 1'b0;
    // Model controls (written only by the main process)
    int  klat = 2, ds_low_cfg = 0;
    bit  kernel_hang = 0, k_abort = 0;

    typedef struct {
        int rc; int klat; int exp_iter; int exp_pulses; int exp_ds; int exp_lat;
    } vec_t;
    vec_t vecs[5];

    function automatic int lat_exp(input int v);
`ifdef RUN_CTRL_LAT_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Responder: kernel (ap_ctrl_hs), dataset loaders and protocol monitors, all on the falling edge
    initial begin
        k_ap_ready = 1'b0;
        k_ap_done  = 1'b0;
        ds_ready   = 1'b1;
        forever begin
            @(negedge clk);
            if (ds_update && prev_upd) upd_wide++;
            if (!ds_ready && k_ap_start) start_low++;
            prev_upd = ds_update;
            if (k_abort) begin
                k_busy = 0; k_ap_ready = 1'b0; k_ap_done = 1'b0;
            end else begin
                k_ap_ready = 1'b0;
                k_ap_done  = 1'b0;
                if (k_busy) begin
                    k_cnt++;
                    if (!kernel_hang && k_cnt == klat) begin
                        k_ap_done = 1'b1;
                        k_busy    = 0;
                    end
                end else if (k_ap_start) begin
                    k_ap_ready = 1'b1;
                    starts++;
                    k_cnt = 0;
                    if (klat == 0) k_ap_done = 1'b1;
                    else           k_busy = 1;
                end
            end
            if (ds_update) pulses++;
            if (ds_update && ds_low_cfg > 0) begin
                ds_ready    = 1'b0;
                ds_low_left = ds_low_cfg;
            end else if (ds_low_left > 0) begin
                ds_low_left--;
                if (ds_low_left == 0) begin
                    ds_ready  = 1'b1;
                    measuring = 1;
                    since     = 0;
                end
            end else if (measuring) begin
                since++;
                if (k_ap_start) begin
                    gap_meas  = since;
                    measuring = 0;
                end
            end
            // k_cnt counts falling edges after the accept; minus one gives rising edges after accept
            if (err_timeout && !prev_err) err_at = k_cnt - 1;
            prev_err = err_timeout;
        end
    end

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done && !busy) seen = 1;
        end
        check("done_wait", longint'(seen), 1);
    endtask

    task automatic run_request(input int rc);
        @(negedge clk);
        run_count = CNT_W'(rc);
        run_req   = 1'b1;
        wait_done(5000);
        @(negedge clk);
        run_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0, p0;
        bit ok;

        vecs[0] = '{20, 2, 20, 9, 1, 2};   // ds_index wraps 7->0, ends at 1
        vecs[1] = '{3, 10, 3, 1, 2, 10};
        vecs[2] = '{1, 0, 1, 0, 2, 1};     // ready+done together: latency 1
        vecs[3] = '{2, 5, 2, 0, 2, 5};     // final run never pulses ds_update
        vecs[4] = '{5, 1, 5, 2, 4, 1};

        ap_rst    = 1'b1;
        run_req   = 1'b0;
        run_count = '0;
        repeat (3) @(negedge clk);
        check("rst_k_ap_start", longint'(k_ap_start), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ds_update", longint'(ds_update), 0);
        check("rst_ds_index", longint'(ds_index), 0);
        check("rst_iter_cnt", longint'(iter_cnt), 0);
        check("rst_err", longint'(err_timeout), 0);
        check("rst_lat_last", longint'(lat_last), 0);
        ap_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            klat = vecs[v].klat;
            s0 = starts; p0 = pulses;
            run_request(vecs[v].rc);
            check($sformatf("v%0d_iter", v), longint'(iter_cnt), vecs[v].exp_iter);
            check($sformatf("v%0d_starts", v), starts - s0, vecs[v].exp_iter);
            check($sformatf("v%0d_pulses", v), pulses - p0, vecs[v].exp_pulses);
            check($sformatf("v%0d_ds_index", v), longint'(ds_index), vecs[v].exp_ds);
            check($sformatf("v%0d_lat_last", v), longint'(lat_last), lat_exp(vecs[v].exp_lat));
            check($sformatf("v%0d_lat_max", v), longint'(lat_max), lat_exp(vecs[v].exp_lat));
            check($sformatf("v%0d_err", v), longint'(err_timeout), 0);
            check($sformatf("v%0d_done", v), longint'(done), 1);
            $display("[TB] vec %0d rc=%0d klat=%0d iter=%0d pulses=%0d ds_index=%0d",
                     v, vecs[v].rc, klat, iter_cnt, pulses - p0, ds_index);
        end

        // Continuous mode: drop run_req while invocation 5 is in flight
        klat = 6; s0 = starts; p0 = pulses;
        @(negedge clk);
        run_count = '0;
        run_req   = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); #1;
            if (starts - s0 >= 5) ok = 1;
        end
        check("cont_5th_start", longint'(ok), 1);
        @(negedge clk);
        run_req = 1'b0;
        wait_done(2000);
        check("cont_iter", longint'(iter_cnt), 5);
        check("cont_starts", starts - s0, 5);
        check("cont_pulses", pulses - p0, 2);
        check("cont_ds_index", longint'(ds_index), 6);
        $display("[TB] continuous iter=%0d ds_index=%0d", iter_cnt, ds_index);
        @(negedge clk);

        // Slow loaders: ds_ready low 50 cycles after the pulse
        klat = 2; ds_low_cfg = 50; s0 = starts; p0 = pulses;
        run_request(3);
        ds_low_cfg = 0;
        check("slow_iter", longint'(iter_cnt), 3);
        check("slow_pulses", pulses - p0, 1);
        check("slow_ds_index", longint'(ds_index), 7);
        check("slow_start_while_low", start_low, 0);
        check("slow_restart_delay", gap_meas, 5);
        $display("[TB] slow loaders iter=%0d restart_delay=%0d", iter_cnt, gap_meas);

        // Watchdog: kernel accepts but never finishes
        kernel_hang = 1; klat = 5; s0 = starts;
        @(negedge clk);
        run_count = CNT_W'(2);
        run_req   = 1'b1;
        wait_done(1000);
        check("to_err", longint'(err_timeout), 1);
        check("to_latency", err_at, 100);
        check("to_iter", longint'(iter_cnt), 0);
        check("to_starts", starts - s0, 1);
        check("to_lat_last_held", longint'(lat_last), lat_exp(2));
        check("to_lat_max", longint'(lat_max), 0);
        $display("[TB] timeout err=%0d at=%0d iter=%0d", err_timeout, err_at, iter_cnt);
        run_req = 1'b0;
        k_abort = 1;
        repeat (2) @(negedge clk);
        k_abort = 0; kernel_hang = 0; klat = 2;
        @(negedge clk);
        run_count = CNT_W'(1);
        run_req   = 1'b1;
        @(negedge clk);
        check("to_err_cleared", longint'(err_timeout), 0);
        wait_done(500);
        check("to_next_iter", longint'(iter_cnt), 1);
        $display("[TB] after timeout err=%0d iter=%0d", err_timeout, iter_cnt);
        @(negedge clk);
        run_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT_DONE with run_req held high across release
        klat = 20; s0 = starts;
        @(negedge clk);
        run_count = CNT_W'(5);
        run_req   = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (starts - s0 >= 1) ok = 1;
        end
        check("rst2_started", longint'(ok), 1);
        repeat (5) @(negedge clk);
        ap_rst = 1'b1; k_abort = 1;
        #1;
        check("rst2_busy", longint'(busy), 0);
        check("rst2_k_ap_start", longint'(k_ap_start), 0);
        check("rst2_ds_index", longint'(ds_index), 0);
        check("rst2_iter", longint'(iter_cnt), 0);
        check("rst2_done", longint'(done), 0);
        @(negedge clk);
        ap_rst = 1'b0; k_abort = 0;
        s0 = starts;
        repeat (20) @(negedge clk);
        check("rst2_no_restart_busy", longint'(busy), 0);
        check("rst2_no_restart_starts", starts - s0, 0);
        run_req = 1'b0;
        @(negedge clk);
        klat = 3;
        run_request(1);
        check("rst2_rerun_iter", longint'(iter_cnt), 1);
        check("rst2_rerun_ds_index", longint'(ds_index), 0);
        $display("[TB] reset sequence iter=%0d ds_index=%0d", iter_cnt, ds_index);

        check("ds_update_width", upd_wide, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
